// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types, widths and a reference round-robin pick for rr_quantum_arbiter.
package rr_arb_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_GRANTED, ST_GAP} arb_state_t;

    localparam int MAX_REQ  = 16;
    localparam int ID_W_MAX = 4;
    localparam int DEAD_W   = 2;

    typedef struct packed {
        logic                found;
        logic [ID_W_MAX-1:0] idx;
    } pick_t;

    // First set bit of req at last_id+1, last_id+2, ... modulo n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [ID_W_MAX-1:0] last_id,
                                      input int n);
        pick_t p;
        p = '0;
        for (int k = n; k >= 1; k--) begin
            int i;
            i = (int'(last_id) + k) % n;
            if (req[i]) p = '{1'b1, ID_W_MAX'(i)};
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: rotate req so last_id+1 sits at bit 0, priority-encode, then un-rotate the index.
module rr_priority_pick
    import rr_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_id,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);
    localparam int W = $clog2(N);

    logic [N-1:0] rot;
    logic [W-1:0] off;
    logic [W:0]   sum;

    always_comb begin
        rot = N'({req, req} >> (int'(last_id) + 1));
        off = '0;
        for (int i = N - 1; i >= 0; i--) if (rot[i]) off = W'(i);
        sum = (W+1)'(last_id) + (W+1)'(off) + (W+1)'(1);
        found = |rot;
        idx = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
    end

endmodule

// File: rtl/rr_quantum_arbiter.sv
// rr_quantum_arbiter: round-robin arbiter with hold quantum, turnaround gap and registered one-hot grant.
// Optional ARB_LOCK_EN adds a lock input that lets the owner keep the grant past its quantum.
module rr_quantum_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int MAX_HOLD    = 8,
    parameter int DEAD_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
`ifdef ARB_LOCK_EN
    input  logic                     lock,
`endif
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     grant_valid,
    output logic                     preempt
);
    localparam int ID_W   = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic              preempt_q, preempt_d;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              lock_i, owner_req, others, expire, arbitrate;

`ifdef ARB_LOCK_EN
    assign lock_i = lock;
`else
    assign lock_i = 1'b0;
`endif

    rr_priority_pick #(.N(N_REQ)) u_pick (
        .req     (req),
        .last_id (last_id_q),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        hold_cnt_d = hold_cnt_q;
        dead_cnt_d = dead_cnt_q;
        preempt_d  = 1'b0;
        arbitrate  = 1'b0;
        owner_req  = req[grant_id_q];
        others     = |(req & ~grant_q);
        expire     = (hold_cnt_q == HOLD_MAX) && others && !lock_i;
        case (state_q)
            ST_IDLE: arbitrate = 1'b1;
            ST_GRANTED: begin
                if (!owner_req || expire) begin
                    // An owner that drops in its expiry cycle is a plain release, not a preemption.
                    preempt_d = owner_req;
                    grant_d   = '0;
                    if (DEAD_CYCLES == 0) begin
                        arbitrate = 1'b1;
                    end else begin
                        state_d    = ST_GAP;
                        dead_cnt_d = '0;
                    end
                end else begin
                    hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_GAP: begin
                if (dead_cnt_q == DEAD_W'(DEAD_CYCLES - 1)) arbitrate = 1'b1;
                else dead_cnt_d = dead_cnt_q + DEAD_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        if (arbitrate) begin
            state_d    = pick_found ? ST_GRANTED : ST_IDLE;
            grant_d    = pick_found ? N_REQ'(1) << pick_idx : '0;
            grant_id_d = pick_found ? pick_idx : grant_id_q;
            last_id_d  = pick_found ? pick_idx : last_id_q;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_id_q  <= ID_W'(N_REQ - 1);
            hold_cnt_q <= '0;
            dead_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            hold_cnt_q <= hold_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = |grant_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_quantum_arbiter.sv
// tb_rr_quantum_arbiter: table, directed and random checks of two arbiters (DEAD_CYCLES 1 and 0) against a queue-free owner/tenure model.
module tb_rr_quantum_arbiter;
    localparam int N    = 4;
    localparam int MAXH = 8;
`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lock = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] g1, g0;
    logic [1:0]   id1, id0;
    logic         v1, v0, p1, p0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_quantum_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH), .DEAD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req(req),
`ifdef ARB_LOCK_EN
        .lock(lock),
`endif
        .grant(g1), .grant_id(id1), .grant_valid(v1), .preempt(p1)
    );

    rr_quantum_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH), .DEAD_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req),
`ifdef ARB_LOCK_EN
        .lock(lock),
`endif
        .grant(g0), .grant_id(id0), .grant_valid(v0), .preempt(p0)
    );

    // Model: who owns the resource, how long they have held it, how many idle cycles remain.
    typedef struct {
        int owner;
        int tenure;
        int gap_left;
        int last;
        bit pre;
    } mdl_t;

    mdl_t m1, m0;

    function automatic mdl_t step(mdl_t m, int dead, logic r, logic [N-1:0] rq, logic lk);
        mdl_t n;
        n = m;
        n.pre = 1'b0;
        if (r) begin
            n.owner = -1; n.tenure = 0; n.gap_left = 0; n.last = N - 1;
            return n;
        end
        if (m.owner >= 0) begin
            bit mine, rivals;
            mine = rq[m.owner];
            rivals = (rq & ~(N'(1) << m.owner)) != '0;
            if (mine && !(m.tenure >= MAXH - 1 && rivals && !lk)) begin
                n.tenure++;
                return n;
            end
            n.pre = mine;
            n.owner = -1;
            n.gap_left = dead;
            if (dead != 0) return n;
        end else if (m.gap_left > 1) begin
            n.gap_left--;
            return n;
        end
        n.gap_left = 0;
        n.owner = -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m.last + k) % N;
            if (rq[i]) begin
                n.owner = i; n.last = i; n.tenure = 0;
                break;
            end
        end
        return n;
    endfunction

    function automatic logic [N-1:0] mgrant(mdl_t m);
        return (m.owner >= 0) ? N'(1) << m.owner : '0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string tag, input mdl_t m, input logic [N-1:0] g,
                           input logic [1:0] gid, input logic gv, input logic pr);
        chk({tag, "_grant"}, 32'(g), 32'(mgrant(m)));
        chk({tag, "_preempt"}, 32'(pr), 32'(m.pre));
        chk({tag, "_onehot0"}, 32'($onehot0(g)), 32'd1);
        chk({tag, "_valid"}, 32'(gv), 32'(|g));
        if (gv) chk({tag, "_grant_id"}, 32'(N'(1) << gid), 32'(g));
    endtask

    task automatic tick();
        m1 = step(m1, 1, rst, req, lock & LOCK_EN);
        m0 = step(m0, 0, rst, req, lock & LOCK_EN);
        @(posedge clk);
        #1;
        cmp_dut("d1", m1, g1, id1, v1, p1);
        cmp_dut("d0", m0, g0, id0, v0, p0);
    endtask

    typedef struct {
        logic         r;
        logic [N-1:0] rq;
        int           reps;
        logic [N-1:0] eg;
        logic         ep;
    } vec_t;

    vec_t tbl[$];

    initial begin
        m1 = '{-1, 0, 0, N - 1, 1'b0};
        m0 = '{-1, 0, 0, N - 1, 1'b0};
        tbl = '{
            '{1'b1, 4'b0000, 1, 4'b0000, 1'b0},
            '{1'b0, 4'b0000, 5, 4'b0000, 1'b0},
            '{1'b0, 4'b1111, 8, 4'b0001, 1'b0},
            '{1'b0, 4'b1111, 1, 4'b0000, 1'b1},
            '{1'b0, 4'b1111, 8, 4'b0010, 1'b0},
            '{1'b0, 4'b1111, 1, 4'b0000, 1'b1},
            '{1'b0, 4'b1111, 8, 4'b0100, 1'b0},
            '{1'b0, 4'b1111, 1, 4'b0000, 1'b1},
            '{1'b0, 4'b1111, 8, 4'b1000, 1'b0},
            '{1'b0, 4'b1111, 1, 4'b0000, 1'b1},
            '{1'b0, 4'b1111, 1, 4'b0001, 1'b0},
            '{1'b0, 4'b0100, 1, 4'b0000, 1'b0},
            '{1'b0, 4'b0100, 20, 4'b0100, 1'b0},
            '{1'b0, 4'b0000, 3, 4'b0000, 1'b0},
            '{1'b1, 4'b0000, 1, 4'b0000, 1'b0},
            '{1'b0, 4'b1001, 3, 4'b0001, 1'b0},
            '{1'b0, 4'b1000, 1, 4'b0000, 1'b0},
            '{1'b0, 4'b1000, 3, 4'b1000, 1'b0},
            '{1'b0, 4'b0010, 1, 4'b0000, 1'b0},
            '{1'b0, 4'b0010, 2, 4'b0010, 1'b0},
            '{1'b1, 4'b1111, 1, 4'b0000, 1'b0},
            '{1'b0, 4'b1111, 1, 4'b0001, 1'b0}
        };
        foreach (tbl[i]) begin
            rst = tbl[i].r;
            req = tbl[i].rq;
            for (int c = 0; c < tbl[i].reps; c++) begin
                tick();
                chk($sformatf("tbl%0d_grant", i), 32'(g1), 32'(tbl[i].eg));
                chk($sformatf("tbl%0d_preempt", i), 32'(p1), 32'(tbl[i].ep));
            end
        end

        // Back-to-back handover with no turnaround gap.
        rst = 1'b1; req = '0; tick();
        rst = 1'b0; req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("nogap_first", 32'(g0), 32'h1);
        end
        tick();
        chk("nogap_switch", 32'(g0), 32'h2);
        chk("nogap_preempt", 32'(p0), 32'h1);
        tick();
        chk("nogap_hold", 32'(g0), 32'h2);

`ifdef ARB_LOCK_EN
        rst = 1'b1; req = '0; tick();
        rst = 1'b0; req = 4'b1111; lock = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("lock_grant", 32'(g1), 32'h1);
            chk("lock_preempt", 32'(p1), 32'h0);
        end
        lock = 1'b0;
        tick();
        chk("unlock_grant", 32'(g1), 32'h0);
        chk("unlock_preempt", 32'(p1), 32'h1);
`endif

        rst = 1'b0;
        for (int b = 0; b < 150; b++) begin
            int len;
            req = N'($urandom_range(0, 15));
            lock = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 40) == 0);
            len = $urandom_range(1, 20);
            for (int c = 0; c < len; c++) begin
                tick();
                rst = 1'b0;
                if ($urandom_range(0, 9) == 0) req = N'($urandom_range(0, 15));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
